// File: rtl/sysid_check_master.sv
// Avalon-MM read master that fetches the two sysid words (ID, timestamp),
// compares them with build-time values and reports pass/fail/timeout.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1489442558,
  parameter bit          USE_READDATAVALID  = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES     = 256,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, FIN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             arm_q;
  logic             is_rd_c, is_wait_c, is_id_c, accept_c, capture_c, expire_c;

  // avm_read is always high in RD_* states, so an accept is just a non-stalled RD_* cycle
  assign is_rd_c   = (state_q == RD_ID) || (state_q == RD_TS);
  assign is_wait_c = (state_q == WAIT_ID) || (state_q == WAIT_TS);
  assign is_id_c   = (state_q == RD_ID) || (state_q == WAIT_ID);
  assign accept_c  = is_rd_c && !avm_waitrequest;
  assign capture_c = (accept_c && (!USE_READDATAVALID || avm_readdatavalid)) ||
                     (is_wait_c && avm_readdatavalid);
  assign expire_c  = (cnt_q == CNT_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      arm_q       <= AUTO_START;
      avm_address <= 1'b0;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start || arm_q) begin
            arm_q       <= 1'b0;
            state_q     <= RD_ID;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            cnt_q       <= CNT_W'(TIMEOUT_CYCLES);
          end
        end
        RD_ID, WAIT_ID, RD_TS, WAIT_TS: begin
          if (capture_c && is_id_c) begin
            id_value    <= avm_readdata;
            state_q     <= RD_TS;
            avm_read    <= 1'b1;
            avm_address <= 1'b1;
            cnt_q       <= CNT_W'(TIMEOUT_CYCLES);
          end else if (capture_c) begin
            ts_value    <= avm_readdata;
            state_q     <= FIN;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b0;
            id_ok       <= (id_value == EXPECTED_ID);
            ts_ok       <= (avm_readdata == EXPECTED_TIMESTAMP);
          end else if (expire_c) begin
            state_q     <= FIN;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            // accepted but data still in flight: drop the strobe and wait for readdatavalid
            if (accept_c) begin
              avm_read <= 1'b0;
              state_q  <= is_id_c ? WAIT_ID : WAIT_TS;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Bench for sysid_check_master: two instances (zero-latency / readdatavalid),
// a transaction-level reference model compared every cycle, plus directed checks.
module tb_sysid_check_master;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1489442558;
  localparam int          T0     = 8;
  localparam int          T1     = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clock = ~clock;

  logic        addr[2], rd[2], wr[2], rdv[2], bsy[2], dn[2], iok[2], tok[2], terr[2];
  logic [31:0] rdata[2], idv[2], tsv[2];

  sysid_check_master #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .USE_READDATAVALID(1'b0), .TIMEOUT_CYCLES(T0), .AUTO_START(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]),
    .avm_readdata(rdata[0]), .avm_readdatavalid(rdv[0]),
    .busy(bsy[0]), .done(dn[0]), .id_ok(iok[0]), .ts_ok(tok[0]),
    .timeout_err(terr[0]), .id_value(idv[0]), .ts_value(tsv[0]));

  sysid_check_master #(.EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .USE_READDATAVALID(1'b1), .TIMEOUT_CYCLES(T1), .AUTO_START(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]),
    .avm_readdata(rdata[1]), .avm_readdatavalid(rdv[1]),
    .busy(bsy[1]), .done(dn[1]), .id_ok(iok[1]), .ts_ok(tok[1]),
    .timeout_err(terr[1]), .id_value(idv[1]), .ts_value(tsv[1]));

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // ---------------- reference model: which word is being fetched and for how long
  int          m_word[2];
  int          m_elapsed[2];
  logic        m_reading[2], m_fin[2], m_arm[2];
  logic        m_addr[2], m_busy[2], m_done[2], m_iok[2], m_tok[2], m_terr[2];
  logic [31:0] m_idv[2], m_tsv[2];

  task automatic begin_read(input int i, input int w);
    m_word[i]    = w;
    m_reading[i] = 1'b1;
    m_elapsed[i] = 0;
    m_addr[i]    = (w == 1);
  endtask

  task automatic finish(input int i, input bit to);
    m_word[i]    = -1;
    m_reading[i] = 1'b0;
    m_fin[i]     = 1'b1;
    m_done[i]    = 1'b1;
    m_busy[i]    = 1'b0;
    m_terr[i]    = to;
    m_iok[i]     = !to && (m_idv[i] == EXP_ID);
    m_tok[i]     = !to && (m_tsv[i] == EXP_TS);
  endtask

  task automatic model_step(input int i);
    bit got;
    int tmax;
    bit use_rdv;
    tmax    = (i == 0) ? T0 : T1;
    use_rdv = (i == 1);
    if (reset) begin
      m_word[i] = -1; m_elapsed[i] = 0; m_reading[i] = 1'b0; m_fin[i] = 1'b0;
      m_arm[i]  = (i == 1);
      m_addr[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      m_iok[i]  = 1'b0; m_tok[i] = 1'b0; m_terr[i] = 1'b0; m_idv[i] = '0; m_tsv[i] = '0;
    end else if (m_fin[i]) begin
      m_fin[i]  = 1'b0;
      m_done[i] = 1'b0;
    end else if (m_word[i] < 0) begin
      if (start || m_arm[i]) begin
        m_arm[i]  = 1'b0;
        m_busy[i] = 1'b1;
        m_iok[i]  = 1'b0; m_tok[i] = 1'b0; m_terr[i] = 1'b0; m_idv[i] = '0; m_tsv[i] = '0;
        begin_read(i, 0);
      end
    end else begin
      got = 1'b0;
      if (m_reading[i] && !wr[i]) begin
        if (!use_rdv || rdv[i]) got = 1'b1;
        else m_reading[i] = 1'b0;
      end else if (!m_reading[i] && rdv[i]) begin
        got = 1'b1;
      end
      if (got && m_word[i] == 0) begin
        m_idv[i] = rdata[i];
        begin_read(i, 1);
      end else if (got) begin
        m_tsv[i] = rdata[i];
        finish(i, 1'b0);
      end else if (m_elapsed[i] + 1 >= tmax) begin
        finish(i, 1'b1);
      end else begin
        m_elapsed[i]++;
      end
    end
  endtask

  always @(posedge clock) for (int i = 0; i < 2; i++) model_step(i);

  function automatic logic [70:0] dut_vec(input int i);
    return {rd[i], addr[i], bsy[i], dn[i], iok[i], tok[i], terr[i], idv[i], tsv[i]};
  endfunction

  function automatic logic [70:0] model_vec(input int i);
    logic r;
    r = (m_word[i] >= 0) && m_reading[i];
    return {r, m_addr[i], m_busy[i], m_done[i], m_iok[i], m_tok[i], m_terr[i], m_idv[i], m_tsv[i]};
  endfunction

  always @(negedge clock)
    if (cmp_en)
      for (int i = 0; i < 2; i++)
        check($sformatf("cycle_dut%0d", i), 128'(dut_vec(i)), 128'(model_vec(i)));

  // ---------------- slave models
  int          s_mode[2];   // 0 no wait, 1 fixed stall, 2 random stall, 3 stuck on address 1
  int          s_stall[2], s_lat[2], s_cnt[2], s_pend[2];
  bit          s_spur[2];
  logic [31:0] s_pdat[2];
  logic [31:0] mem[2][2];
  int          acc_cnt[2]  = '{0, 0};
  int          done_cnt[2] = '{0, 0};

  task automatic slave_step(input int i);
    bit acc;
    case (s_mode[i])
      0: wr[i] = 1'b0;
      1: if (rd[i] && s_cnt[i] < s_stall[i]) begin wr[i] = 1'b1; s_cnt[i]++; end
         else begin wr[i] = 1'b0; s_cnt[i] = 0; end
      2: wr[i] = ($urandom_range(0, 3) == 0);
      default: wr[i] = (addr[i] == 1'b1);
    endcase
    acc      = rd[i] && !wr[i];
    rdv[i]   = 1'b0;
    rdata[i] = $urandom;
    if (acc) acc_cnt[i]++;
    if (i == 0) begin
      if (acc) rdata[i] = mem[i][addr[i]];
    end else if (acc && s_lat[i] == 0) begin
      rdv[i] = 1'b1; rdata[i] = mem[i][addr[i]];
    end else if (acc) begin
      s_pend[i] = s_lat[i]; s_pdat[i] = mem[i][addr[i]];
    end else if (s_pend[i] > 0) begin
      s_pend[i]--;
      if (s_pend[i] == 0) begin rdv[i] = 1'b1; rdata[i] = s_pdat[i]; end
    end
    if (!rdv[i] && s_spur[i] && !bsy[i] && $urandom_range(0, 3) == 0) rdv[i] = 1'b1;
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (dn[i] === 1'b1) done_cnt[i]++;
      slave_step(i);
    end
  end

  task automatic wait_done(input int i, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clock);
      if (dn[i]) ok = 1'b1;
    end
    check($sformatf("wait_done_dut%0d", i), 128'(ok), 128'(1));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int k;
    int n;
    for (int i = 0; i < 2; i++) begin
      s_cnt[i] = 0; s_pend[i] = 0; s_spur[i] = 1'b0; s_pdat[i] = '0;
      wr[i] = 1'b0; rdv[i] = 1'b0; rdata[i] = '0;
      mem[i][0] = EXP_ID; mem[i][1] = EXP_TS;
    end
    s_mode[0] = 0; s_stall[0] = 0; s_lat[0] = 0;
    s_mode[1] = 1; s_stall[1] = 5; s_lat[1] = 2;

    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) check($sformatf("reset_outs_dut%0d", i), 128'(dut_vec(i)), 128'(0));
    cmp_en = 1'b1;
    reset  = 1'b0;
    @(negedge clock);
    check("auto_start_busy", 128'({bsy[1], rd[1], addr[1]}), 128'(3'b110));

    // nominal on the zero-latency instance; dut1 is busy so this start must be dropped there
    pulse_start();
    check("nom_c1_rd_addr", 128'({rd[0], addr[0]}), 128'(2'b10));
    @(negedge clock);
    check("nom_c2_rd_addr", 128'({rd[0], addr[0]}), 128'(2'b11));
    @(negedge clock);
    check("nom_c3_status", 128'({dn[0], bsy[0], iok[0], tok[0], terr[0]}), 128'(5'b10110));

    wait_done(1, 100);
    check("stall_status", 128'({iok[1], tok[1], terr[1]}), 128'(3'b110));
    repeat (5) @(negedge clock);
    check("stall_one_done", 128'(done_cnt[1]), 128'(1));
    check("stall_two_accepts", 128'(acc_cnt[1]), 128'(2));

    // timestamp mismatch
    mem[0][1] = 32'h1234_5678;
    pulse_start();
    wait_done(0, 20);
    check("mm_status", 128'({iok[0], tok[0], terr[0]}), 128'(3'b100));
    check("mm_ts_value", 128'(tsv[0]), 128'(32'h1234_5678));
    repeat (40) @(negedge clock);

    // timeout with waitrequest stuck on address 1
    mem[0][0] = 32'hCAFE_0001;
    mem[0][1] = EXP_TS;
    s_mode[0] = 3;
    pulse_start();
    k = 0;
    while (!(rd[0] && addr[0]) && k < 20) begin @(negedge clock); k++; end
    n = 0;
    while (!dn[0] && n < 30) begin @(negedge clock); n++; end
    check("to_latency", 128'(n), 128'(8));
    check("to_status", 128'({iok[0], tok[0], terr[0]}), 128'(3'b001));
    check("to_id_retained", 128'(idv[0]), 128'(32'hCAFE_0001));
    s_mode[0] = 0;
    mem[0][0] = EXP_ID;
    repeat (40) @(negedge clock);

    // reset while dut1 waits for the ID data
    pulse_start();
    k = 0;
    while (!(bsy[1] && !rd[1] && !addr[1]) && k < 30) begin @(negedge clock); k++; end
    check("found_wait_id", 128'(k < 30), 128'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_mid_flags", 128'({rd[1], bsy[1], dn[1], iok[1], tok[1], terr[1]}), 128'(0));
    check("rst_mid_values", 128'({idv[1], tsv[1]}), 128'(0));
    wait_done(1, 100);
    check("rst_rearm_status", 128'({iok[1], tok[1], terr[1]}), 128'(3'b110));

    // randomized traffic, checked cycle by cycle against the model
    s_spur[1] = 1'b1;
    for (int it = 0; it < 40; it++) begin
      s_mode[0]  = $urandom_range(0, 2);
      s_mode[1]  = $urandom_range(0, 3);
      s_stall[1] = $urandom_range(0, 6);
      s_lat[1]   = $urandom_range(0, 3);
      for (int i = 0; i < 2; i++)
        for (int w = 0; w < 2; w++)
          mem[i][w] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : ((w == 1) ? EXP_TS : EXP_ID);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        start = ($urandom_range(0, 1) == 1);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
      end
      pulse_start();
      n = $urandom_range(5, 40);
      for (int c = 0; c < n; c++) begin
        start = ($urandom_range(0, 15) == 0);
        @(negedge clock);
      end
      start = 1'b0;
    end
    repeat (40) @(negedge clock);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that sequences the two-word system ID slave at boot or on demand: word 0 is the ID, word 1 is the timestamp.
- Compares both words against build-time expected values and publishes pass/fail/timeout status to the Nios II reset/boot logic and the status LEDs.
- Sits between the system reset controller and the sysid control_slave, on a single clock domain.

Parameters:
- EXPECTED_ID, 32'd0: expected word at address 0.
- EXPECTED_TIMESTAMP, 32'd1489442558: expected word at address 1.
- USE_READDATAVALID, 0: 0 = data captured in the accept cycle (zero-latency slave); 1 = data captured on avm_readdatavalid.
- TIMEOUT_CYCLES, 256: per-read cycle limit from read assertion to data capture; range 2..65535.
- AUTO_START, 1: 1 = a check runs automatically on the first cycle after reset deasserts.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: single-cycle request to run a check; ignored while busy.
- avm_address, out, 1: slave word address.
- avm_read, out, 1: read strobe.
- avm_waitrequest, in, 1: slave stall.
- avm_readdata, in, 32: slave read data.
- avm_readdatavalid, in, 1: read data valid; used only when USE_READDATAVALID=1.
- busy, out, 1: a check is in progress.
- done, out, 1: one-cycle pulse when a check ends.
- id_ok, out, 1: captured ID equals EXPECTED_ID.
- ts_ok, out, 1: captured timestamp equals EXPECTED_TIMESTAMP.
- timeout_err, out, 1: the last check aborted on timeout.
- id_value, out, 32: captured ID word.
- ts_value, out, 32: captured timestamp word.

Behaviour:
- Reset values:
  - All outputs are 0 and state is IDLE.
  - A pending auto-start is armed iff AUTO_START=1.
- FSM states are IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, FIN.
- IDLE:
  - Leaves on start=1 or on the armed auto-start; the auto-start is consumed.
  - On leaving: go to RD_ID, set busy=1, clear id_ok, ts_ok, timeout_err, id_value and ts_value, and load the timeout counter.
- RD_ID:
  - Drive avm_read=1, avm_address=0.
  - Address and read are held stable while avm_waitrequest=1.
  - Accept occurs when avm_read=1 and avm_waitrequest=0.
  - If USE_READDATAVALID=0: capture avm_readdata into id_value in the accept cycle and go to RD_TS.
  - If USE_READDATAVALID=1: go to WAIT_ID. If avm_readdatavalid=1 in the accept cycle itself, capture id_value and go directly to RD_TS.
- WAIT_ID:
  - avm_read=0.
  - Capture id_value on avm_readdatavalid=1, then go to RD_TS.
- RD_TS / WAIT_TS: identical to RD_ID / WAIT_ID, with avm_address=1 and capture into ts_value. Exit goes to FIN.
- FIN:
  - Hold for one cycle with avm_read=0.
  - Assert done=1 and busy=0.
  - Register id_ok = (id_value==EXPECTED_ID) and ts_ok = (ts_value==EXPECTED_TIMESTAMP); both are valid in the cycle done=1 and held until the next check starts.
  - Then go to IDLE.
- Timeout:
  - The counter loads TIMEOUT_CYCLES on entry to each RD_* state and decrements each cycle spent in RD_*/WAIT_*.
  - If it reaches 0 without a capture, go to FIN with timeout_err=1 and id_ok=ts_ok=0.
  - Values already captured are retained.
- A readdatavalid arriving in IDLE, RD_TS or FIN is ignored.
- Reading the same address twice in a row is never issued.
- start asserted while busy=1, or in the FIN cycle, is dropped with no queueing.
- A start that coincides with reset is ignored.
- Reset mid-operation: on the reset edge, avm_read=0 and all status is cleared. Auto-start re-arms per AUTO_START.
- No combinational path exists from any input to any output. All outputs are registered.
- Latency with a zero-wait, zero-latency slave: start at cycle 0 → avm_read on cycles 1–2 → done at cycle 3. Total = 3 cycles.

Test Plan:
- Nominal: AUTO_START=0, slave returns 0 at address 0 and 1489442558 at address 1, no waits; pulse start → avm_read high cycles 1–2 with addresses 0 then 1; done at cycle 3; id_ok=1, ts_ok=1, timeout_err=0.
- Mismatch: slave timestamp 0x12345678 → done; id_ok=1, ts_ok=0, ts_value=0x12345678.
- Stall + latency: USE_READDATAVALID=1, waitrequest high 5 cycles per read, readdatavalid 2 cycles after accept → address/read stable throughout the stalls; exactly 2 accepts; done with id_ok=ts_ok=1; start pulsed mid-check is ignored (exactly one done).
- Timeout: TIMEOUT_CYCLES=8, waitrequest stuck high on address 1 → done 8 cycles after RD_TS entry; timeout_err=1, id_ok=ts_ok=0, id_value retained.
- Reset mid-check: reset high during WAIT_ID → next cycle avm_read=0, busy=0, all status 0; with AUTO_START=1 a new check starts on the first cycle after reset deasserts and completes normally.
